// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state codes, opcode/funct constants, control encodings and a control-word struct
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_I  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_ALU_WB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_SLL = 5'b01000;
  localparam logic [4:0] ALU_SRL = 5'b01001;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_TGT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_r;
    logic       mem_w;
    logic       ir_write;
    logic       mem2r;
    logic       reg_dst;
    logic       reg_w;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] ext_op;
    logic [4:0] aluctrl;
  } ctrl_t;

  function automatic logic is_boundary(input state_e s);
    is_boundary = s inside {S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP};
  endfunction

  function automatic state_e dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:        dispatch = S_EXEC_R;
      OP_ADDI, OP_ORI: dispatch = S_EXEC_I;
      OP_LW, OP_SW:    dispatch = S_MEM_ADR;
      OP_BEQ:          dispatch = S_BRANCH;
      OP_J:            dispatch = S_JUMP;
      default:         dispatch = S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// alu_decode: R-type funct field to ALU control code, with a flag for recognised functs
module alu_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [4:0] aluctrl_o,
  output logic       valid_o
);

  always_comb begin
    aluctrl_o = ALU_AND;
    valid_o   = 1'b1;
    case (funct_i)
      FN_ADD:  aluctrl_o = ALU_ADD;
      FN_SUB:  aluctrl_o = ALU_SUB;
      FN_AND:  aluctrl_o = ALU_AND;
      FN_OR:   aluctrl_o = ALU_OR;
      FN_SLT:  aluctrl_o = ALU_SLT;
      FN_SLL:  aluctrl_o = ALU_SLL;
      FN_SRL:  aluctrl_o = ALU_SRL;
      default: valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style multicycle MIPS-subset control FSM with run/step control and sticky halt
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit FETCH_AT_RESET = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Step,
  input  logic [5:0] OpCode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PcWrite,
  output logic       PcWriteCond,
  output logic       IorD,
  output logic       MemR,
  output logic       MemW,
  output logic       IRWrite,
  output logic       Mem2R,
  output logic       RegDst,
  output logic       RegW,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] PcSource,
  output logic [1:0] ExtOp,
  output logic [4:0] Aluctrl,
  output logic [3:0] State,
  output logic       Halted,
  output logic       Busy
);

  state_e     state_q, state_d;
  logic       rtype_q, rtype_d;
  logic [4:0] fn_ctrl;
  logic       fn_valid;
  ctrl_t      ctrl;
  logic       unused_zero;

  // Branch resolution on Zero happens in the datapath via PcWriteCond
  assign unused_zero = Zero;

  alu_decode u_alu_decode (
    .funct_i   (funct),
    .aluctrl_o (fn_ctrl),
    .valid_o   (fn_valid)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= (FETCH_AT_RESET && Run) ? S_FETCH : S_IDLE;
      rtype_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rtype_q <= rtype_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rtype_d = (state_q == S_EXEC_R) ? 1'b1 : (state_q == S_EXEC_I) ? 1'b0 : rtype_q;
    case (state_q)
      S_IDLE:    state_d = (Run || Step) ? S_FETCH : S_IDLE;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = dispatch(OpCode);
      S_EXEC_R:  state_d = fn_valid ? S_ALU_WB : S_HALT;
      S_EXEC_I:  state_d = S_ALU_WB;
      S_MEM_ADR: state_d = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = S_MEM_WB;
      default:   state_d = is_boundary(state_q) ? (Run ? S_FETCH : S_IDLE) : S_HALT;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_r     = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_source = PCS_ALU;
        ctrl.aluctrl   = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BOFF;
        ctrl.ext_op    = EXT_SIGN;
        ctrl.aluctrl   = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.aluctrl   = fn_ctrl;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = (OpCode == OP_ORI) ? EXT_ZERO : EXT_SIGN;
        ctrl.aluctrl   = (OpCode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = EXT_SIGN;
        ctrl.aluctrl   = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.iord  = 1'b1;
        ctrl.mem_r = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_w = 1'b1;
        ctrl.mem2r = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord  = 1'b1;
        ctrl.mem_w = 1'b1;
      end
      S_ALU_WB: begin
        ctrl.reg_w   = 1'b1;
        ctrl.reg_dst = rtype_q;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.aluctrl       = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_TGT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JMP;
      end
      default: ;
    endcase
  end

  // Reset forces every strobe low immediately, even though the state may already read FETCH
  assign {PcWrite, PcWriteCond, IorD, MemR, MemW, IRWrite, Mem2R, RegDst, RegW, AluSrcA,
          AluSrcB, PcSource, ExtOp, Aluctrl} = Reset ? ctrl : '0;
  assign State  = state_q;
  assign Halted = Reset && (state_q == S_HALT);
  assign Busy   = Reset && !(state_q inside {S_IDLE, S_HALT});

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; tasks push expected per-cycle control, a negedge monitor compares
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       Clk = 1'b0, Reset = 1'b0, Run = 1'b1, Step = 1'b0, Zero = 1'b0;
  logic [5:0] OpCode = OP_RTYPE, funct = FN_ADD;
  logic       PcWrite, PcWriteCond, IorD, MemR, MemW, IRWrite, Mem2R, RegDst, RegW, AluSrcA;
  logic [1:0] AluSrcB, PcSource, ExtOp;
  logic [4:0] Aluctrl;
  logic [3:0] State;
  logic       Halted, Busy;
  logic [13:0] sig;

  multicycle_ctrl #(.FETCH_AT_RESET(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Step(Step), .OpCode(OpCode), .funct(funct), .Zero(Zero),
    .PcWrite(PcWrite), .PcWriteCond(PcWriteCond), .IorD(IorD), .MemR(MemR), .MemW(MemW),
    .IRWrite(IRWrite), .Mem2R(Mem2R), .RegDst(RegDst), .RegW(RegW), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .PcSource(PcSource), .ExtOp(ExtOp), .Aluctrl(Aluctrl), .State(State),
    .Halted(Halted), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  assign sig = {PcWrite, PcWriteCond, IorD, MemR, MemW, IRWrite, Mem2R, RegDst, RegW, AluSrcA,
                AluSrcB, Busy, Halted};

  typedef struct {
    logic [3:0]  st;
    logic [13:0] sig;
    logic [4:0]  alu;
    logic [1:0]  ext;
    logic [1:0]  src;
    bit          chk_alu;
  } exp_t;

  exp_t  sb[$];
  exp_t  e;
  int    checks = 0, failures = 0, alu_wb_seen = 0;
  bit    rt_exp = 1'b0;
  string cur = "reset";

  // {PcWrite,PcWriteCond,IorD,MemR,MemW,IRWrite,Mem2R,RegDst,RegW,AluSrcA,AluSrcB,Busy,Halted}
  function automatic logic [13:0] exp_sig(input logic [3:0] s, input bit rt);
    case (s)
      S_FETCH:   exp_sig = {10'b1001010000, 2'b01, 2'b10};
      S_DECODE:  exp_sig = {10'b0000000000, 2'b11, 2'b10};
      S_EXEC_R:  exp_sig = {10'b0000000001, 2'b00, 2'b10};
      S_EXEC_I:  exp_sig = {10'b0000000001, 2'b10, 2'b10};
      S_MEM_ADR: exp_sig = {10'b0000000001, 2'b10, 2'b10};
      S_MEM_RD:  exp_sig = {10'b0011000000, 2'b00, 2'b10};
      S_MEM_WB:  exp_sig = {10'b0000001010, 2'b00, 2'b10};
      S_MEM_WR:  exp_sig = {10'b0010100000, 2'b00, 2'b10};
      S_ALU_WB:  exp_sig = {7'b0000000, rt, 2'b10, 2'b00, 2'b10};
      S_BRANCH:  exp_sig = {10'b0100000001, 2'b00, 2'b10};
      S_JUMP:    exp_sig = {10'b1000000000, 2'b00, 2'b10};
      S_HALT:    exp_sig = {10'b0000000000, 2'b00, 2'b01};
      default:   exp_sig = '0;
    endcase
  endfunction

  task automatic push(input logic [3:0] s, input logic [4:0] alu = 5'd0,
                      input logic [1:0] ext = 2'd0, input logic [1:0] src = 2'd0, input bit ca = 1'b1);
    sb.push_back('{s, exp_sig(s, rt_exp), alu, ext, src, ca});
  endtask

  task automatic push_fd();
    push(S_FETCH, ALU_ADD, EXT_ZERO, PCS_ALU);
    push(S_DECODE, ALU_ADD, EXT_SIGN, PCS_ALU);
  endtask

  always @(negedge Clk) begin
    if (State === S_ALU_WB) alu_wb_seen++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (State !== e.st || sig !== e.sig || ExtOp !== e.ext || PcSource !== e.src ||
          (e.chk_alu && Aluctrl !== e.alu)) begin
        failures++;
        $display("FAIL sb[%s] t=%0t got State=%0d sig=%b alu=%b ext=%b src=%b, expected State=%0d sig=%b alu=%b ext=%b src=%b",
                 cur, $time, State, sig, Aluctrl, ExtOp, PcSource, e.st, e.sig, e.alu, e.ext, e.src);
      end
    end
  end

  task automatic wait_sb();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain[%s] %0d entries left, expected 0", cur, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    cur = "reset";
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (State !== S_FETCH || {MemR, PcWrite, IRWrite, MemW, RegW} !== 5'b0 || Halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold State=%0d strobes=%b Halted=%b, expected State=%0d strobes=00000 Halted=0",
               State, {MemR, PcWrite, IRWrite, MemW, RegW}, Halted, S_FETCH);
    end
    Reset = 1'b1;
  endtask

  task automatic test_rtype();
    logic [5:0] fns[7]  = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL};
    logic [4:0] alus[7] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL};
    cur = "rtype";
    rt_exp = 1'b1;
    for (int i = 0; i < 7; i++) begin
      OpCode = OP_RTYPE;
      funct = fns[i];
      push_fd();
      push(S_EXEC_R, alus[i]);
      push(S_ALU_WB);
      wait_sb();
    end
  endtask

  task automatic test_itype();
    cur = "itype";
    rt_exp = 1'b0;
    OpCode = OP_ADDI;
    push_fd();
    push(S_EXEC_I, ALU_ADD, EXT_SIGN);
    push(S_ALU_WB);
    wait_sb();
    OpCode = OP_ORI;
    push_fd();
    push(S_EXEC_I, ALU_OR, EXT_ZERO);
    push(S_ALU_WB);
    wait_sb();
  endtask

  task automatic test_mem();
    cur = "lw";
    OpCode = OP_LW;
    push_fd();
    push(S_MEM_ADR, ALU_ADD, EXT_SIGN);
    push(S_MEM_RD);
    push(S_MEM_WB);
    wait_sb();
    cur = "sw";
    OpCode = OP_SW;
    push_fd();
    push(S_MEM_ADR, ALU_ADD, EXT_SIGN);
    push(S_MEM_WR);
    wait_sb();
  endtask

  task automatic test_branch_jump();
    for (int z = 0; z < 2; z++) begin
      cur = z ? "beq_z1" : "beq_z0";
      Zero = z[0];
      OpCode = OP_BEQ;
      push_fd();
      push(S_BRANCH, ALU_SUB, EXT_ZERO, PCS_TGT);
      wait_sb();
    end
    cur = "jump";
    Zero = 1'b0;
    OpCode = OP_J;
    push_fd();
    push(S_JUMP, 5'd0, EXT_ZERO, PCS_JMP);
    wait_sb();
  endtask

  task automatic test_run_drop();
    cur = "run_drop";
    OpCode = OP_SW;
    push_fd();
    push(S_MEM_ADR, ALU_ADD, EXT_SIGN);
    push(S_MEM_WR);
    push(S_IDLE);
    @(posedge Clk);
    #1;
    Run = 1'b0;
    wait_sb();
  endtask

  task automatic test_step();
    cur = "step";
    OpCode = OP_ORI;
    alu_wb_seen = 0;
    for (int n = 0; n < 3; n++) begin
      Step = 1'b1;
      push(S_IDLE);
      push_fd();
      push(S_EXEC_I, ALU_OR, EXT_ZERO);
      push(S_ALU_WB);
      repeat (5) push(S_IDLE);
      @(posedge Clk);
      #1;
      Step = 1'b0;
      wait_sb();
    end
    checks++;
    if (alu_wb_seen !== 3) begin
      failures++;
      $display("FAIL step_count ALU_WB seen %0d, expected 3", alu_wb_seen);
    end
  endtask

  task automatic test_step_held();
    cur = "step_held";
    Step = 1'b1;
    for (int n = 0; n < 2; n++) begin
      push(S_IDLE);
      push_fd();
      push(S_EXEC_I, ALU_OR, EXT_ZERO);
      push(S_ALU_WB);
    end
    wait_sb();
    Step = 1'b0;
  endtask

  task automatic reset_pulse(input string tag);
    Reset = 1'b0;
    #1;
    checks++;
    if (State !== S_FETCH || Halted !== 1'b0 || {MemR, PcWrite, IRWrite, MemW} !== 4'b0) begin
      failures++;
      $display("FAIL %s State=%0d Halted=%b strobes=%b, expected State=%0d Halted=0 strobes=0000",
               tag, State, Halted, {MemR, PcWrite, IRWrite, MemW}, S_FETCH);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
  endtask

  task automatic test_halt();
    cur = "halt_op";
    Run = 1'b1;
    Step = 1'b1;
    OpCode = 6'b111111;
    push(S_IDLE);
    push_fd();
    repeat (20) push(S_HALT);
    wait_sb();
    Step = 1'b0;
    reset_pulse("halt_clear");
    cur = "halt_fn";
    OpCode = OP_RTYPE;
    funct = 6'b111111;
    push_fd();
    push(S_EXEC_R, 5'd0, EXT_ZERO, PCS_ALU, 1'b0);
    repeat (3) push(S_HALT);
    wait_sb();
    reset_pulse("halt_fn_clear");
    funct = FN_ADD;
  endtask

  task automatic test_reset_mid();
    cur = "reset_mid";
    OpCode = OP_SW;
    push_fd();
    push(S_MEM_ADR, ALU_ADD, EXT_SIGN);
    wait_sb();
    checks++;
    if (State !== S_MEM_WR || MemW !== 1'b1) begin
      failures++;
      $display("FAIL memwr_pre State=%0d MemW=%b, expected State=%0d MemW=1", State, MemW, S_MEM_WR);
    end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (MemW !== 1'b0 || IorD !== 1'b0 || State !== S_FETCH) begin
      failures++;
      $display("FAIL memwr_async MemW=%b IorD=%b State=%0d, expected MemW=0 IorD=0 State=%0d",
               MemW, IorD, State, S_FETCH);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    cur = "after_reset";
    push_fd();
    push(S_MEM_ADR, ALU_ADD, EXT_SIGN);
    push(S_MEM_WR);
    wait_sb();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_mem();
    test_branch_jump();
    test_run_drop();
    test_step();
    test_step_held();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The module SHALL have parameter FETCH_AT_RESET, default 1, meaning that after reset it starts in FETCH when Run=1 (0: it starts in IDLE regardless of Run).
REQ-002 The module SHALL have port Clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port Run, input, 1, free-run enable sampled at instruction boundaries.
REQ-005 The module SHALL have port Step, input, 1, single-instruction request, level-sampled in IDLE.
REQ-006 The module SHALL have port OpCode, input, 6, IR[31:26].
REQ-007 The module SHALL have port funct, input, 6, IR[5:0].
REQ-008 The module SHALL have port Zero, input, 1, ALU zero flag.
REQ-009 The module SHALL have the following 1-bit outputs: PcWrite, PcWriteCond, IorD, MemR, MemW, IRWrite, Mem2R, RegDst, RegW and AluSrcA.
REQ-010 The module SHALL have the following outputs: AluSrcB (2 bits), PcSource (2 bits), ExtOp (2 bits) and Aluctrl (5 bits).
REQ-011 The module SHALL have the following outputs: State (4 bits, current state code), Halted (1 bit, sticky illegal-opcode flag) and Busy (1 bit, high outside IDLE/HALT).

Function
REQ-012 States SHALL be IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP and HALT.
REQ-013 All outputs SHALL be Moore outputs that are a pure function of State; outputs not asserted in a state SHALL be 0.
REQ-014 FETCH SHALL assert MemR, IRWrite and PcWrite, with IorD=0, AluSrcA=0, AluSrcB=01 (+4), PcSource=00 and Aluctrl=ADD, and SHALL then go to DECODE.
REQ-015 DECODE SHALL set AluSrcA=0, AluSrcB=11 (sign-extended offset <<2), ExtOp=SIGN and Aluctrl=ADD (branch target precompute).
REQ-016 DECODE SHALL dispatch as follows: 000000->EXEC_R; 001000/001101->EXEC_I; 100011/101011->MEM_ADR; 000100->BRANCH; 000010->JUMP; any other opcode->HALT with Halted=1.
REQ-017 EXEC_R SHALL set AluSrcA=1 and AluSrcB=00, and SHALL set Aluctrl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL.
REQ-018 An unknown funct in EXEC_R SHALL go to HALT next cycle instead of ALU_WB.
REQ-019 EXEC_I SHALL set AluSrcA=1 and AluSrcB=10; for addi it SHALL set ExtOp=SIGN and Aluctrl=ADD, and for ori ExtOp=ZERO and Aluctrl=OR.
REQ-020 ALU_WB SHALL assert RegW with Mem2R=0; RegDst SHALL be 1 after EXEC_R and 0 after EXEC_I, held via a registered R-type flag.
REQ-021 MEM_ADR SHALL set AluSrcA=1, AluSrcB=10, ExtOp=SIGN and Aluctrl=ADD, and SHALL go to MEM_RD for lw or MEM_WR for sw.
REQ-022 MEM_RD SHALL assert MemR with IorD=1 and SHALL go to MEM_WB; MEM_WB SHALL assert RegW with Mem2R=1 and RegDst=0.
REQ-023 MEM_WR SHALL assert MemW with IorD=1.
REQ-024 BRANCH SHALL set AluSrcA=1, AluSrcB=00, Aluctrl=SUB, PcWriteCond=1 and PcSource=01; the PC SHALL be updated only when Zero=1 (the datapath gates this).
REQ-025 JUMP SHALL assert PcWrite with PcSource=10.
REQ-026 The instruction boundary SHALL be the last state of each instruction (ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP); from it the next state SHALL be FETCH if Run=1, else IDLE.
REQ-027 Instruction latency SHALL be: beq/j 3 cycles; R-type, addi, ori and sw 4 cycles; lw 5 cycles.
REQ-028 In IDLE, the FSM SHALL go to FETCH if Run=1 or Step=1, and otherwise remain in IDLE.
REQ-029 A Step held high SHALL execute one instruction per IDLE visit (IDLE is occupied 1 cycle between steps).
REQ-030 Deasserting Run mid-instruction SHALL let the current instruction complete; there SHALL be no partial abort.
REQ-031 HALT SHALL be absorbing until Reset; Run and Step SHALL be ignored in HALT, all strobes SHALL be 0, and Halted=1.
REQ-032 No state SHALL assert both MemR and MemW, or both RegW and MemW.

Reset
REQ-033 While Reset=0, the state SHALL be FETCH if FETCH_AT_RESET=1 and Run=1 at release, else IDLE, and every strobe output SHALL be 0.
REQ-034 Reset SHALL clear Halted=0 and the R-type flag=0.
REQ-035 Reset asserted mid-instruction SHALL drop all strobes asynchronously, with no write completed afterward.

Structure
REQ-036 A shared package SHALL hold the state enum/codes, the opcode and funct constants, the Aluctrl codes (ADD, SUB, AND, OR, SLT, SLL, SRL) and the ExtOp codes (ZERO, SIGN).
REQ-037 A combinational sub-module alu_decode (funct -> Aluctrl plus a valid flag) SHALL be used; it is reused by EXEC_R.

Verification
REQ-038 Bench scenario: Run=1, OpCode=000000, funct=100000 -> states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; RegW=1 and RegDst=1 only in ALU_WB; Aluctrl=ADD in EXEC_R.
REQ-039 Bench scenario: lw (100011) -> 5 cycles; MemR=1 in FETCH and MEM_RD; IorD=1 only in MEM_RD; RegW=1 with Mem2R=1 in MEM_WB.
REQ-040 Bench scenario: beq with Zero=0, then with Zero=1 -> 3 cycles each; PcWriteCond=1 and PcSource=01 in BRANCH; PcWrite=0 in BRANCH.
REQ-041 Bench scenario: Run=0, 3 Step pulses of 1 cycle each spaced 10 cycles, with ori -> exactly 3 ALU_WB occurrences; the FSM parks in IDLE, and Busy=0 between steps.
REQ-042 Bench scenario: OpCode=111111 -> HALT on the cycle after DECODE, Halted=1, strobes 0; it stays in HALT with Run=1 for 20 cycles; Reset=0 then clears it.
REQ-043 Bench scenario: Reset=0 asserted during MEM_WR -> MemW drops before the next edge; after release the FSM enters FETCH with Run=1.
